// File: rtl/bseq_pkg.sv
// ---------------------------------------------------------------------------
// bseq_pkg
// Shared types and default sizing for the Booth operand sequencer.
//   bseq_state_e : sequencer FSM states
//   BSEQ_NB      : default operand width
//   BSEQ_DEPTH   : default operand FIFO depth
//   OUT_W        : result width for the default operand width (2*NB+4)
//   PTR_W        : FIFO index width for the default depth
// ---------------------------------------------------------------------------
package bseq_pkg;

  localparam int BSEQ_NB    = 8;
  localparam int BSEQ_DEPTH = 4;
  localparam int OUT_W      = 2*BSEQ_NB + 4;
  localparam int PTR_W      = $clog2(BSEQ_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } bseq_state_e;

endpackage

// File: rtl/bseq_fifo.sv
// ---------------------------------------------------------------------------
// bseq_fifo
// Synchronous FIFO holding operand entries ahead of the sequencer FSM.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate occupancy counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push, wdata: write request and entry; ignored while full
//   pop        : read request; ignored while empty
//   rdata      : current head entry (valid while !empty)
//   full, empty: status flags
// ---------------------------------------------------------------------------
module bseq_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int W_PTR = $clog2(DEPTH);

  logic [W-1:0]   r_mem [DEPTH];
  logic [W_PTR:0] r_wr;
  logic [W_PTR:0] r_rd;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign empty = (r_wr == r_rd);
  // Same slot index but opposite wrap bit: writer is one lap ahead.
  assign full  = (r_wr[W_PTR] != r_rd[W_PTR]) &&
                 (r_wr[W_PTR-1:0] == r_rd[W_PTR-1:0]);
  assign rdata = r_mem[r_rd[W_PTR-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (W_PTR+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (W_PTR+1)'(1);
    end
  end

  // Storage is data only; its contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[W_PTR-1:0]] <= wdata;
  end

endmodule

// File: rtl/booth_seq.sv
// ---------------------------------------------------------------------------
// booth_seq
// Operand sequencer around an iterative radix-4 Booth multiplier.
// Operand pairs are buffered in a FIFO, issued one at a time with a single
// cycle start pulse, and each product is presented on a valid/ready output.
//
// Optional feature macro: BSEQ_ACCUM_EN
//   defined   : products accumulate; only pairs tagged in_last produce an
//               output (accumulated sum), accumulator clears on that handshake
//   undefined : in_last ignored, every product is emitted
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake (in_ready = FIFO not full)
//   in_a, in_b, in_last   : signed operands and group end marker
//   mul_start             : one-cycle start pulse to the multiplier
//   mul_a, mul_b          : registered operands, stable while multiplying
//   mul_product, mul_ready: multiplier result and done flag
//   out_valid/out_ready   : downstream handshake
//   out_product           : sign-extended signed result (2*NB+4 bits)
//   busy                  : FSM not idle or FIFO not empty
// ---------------------------------------------------------------------------
module booth_seq
  import bseq_pkg::*;
#(
  parameter int NB    = BSEQ_NB,
  parameter int DEPTH = BSEQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [NB-1:0]   in_a,
  input  logic signed [NB-1:0]   in_b,
  input  logic                   in_last,
  output logic                   mul_start,
  output logic signed [NB-1:0]   mul_a,
  output logic signed [NB-1:0]   mul_b,
  input  logic signed [2*NB-1:0] mul_product,
  input  logic                   mul_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [2*NB+3:0] out_product,
  output logic                   busy
);

  localparam int W_OUT = 2*NB + 4;
`ifdef BSEQ_ACCUM_EN
  localparam int W_ENT = 2*NB + 1;
`else
  localparam int W_ENT = 2*NB;
`endif

  function automatic logic signed [W_OUT-1:0] f_sext(input logic signed [2*NB-1:0] p);
    return {{4{p[2*NB-1]}}, p};
  endfunction

  bseq_state_e             r_state;
  logic                    r_start;
  logic signed [NB-1:0]    r_a;
  logic signed [NB-1:0]    r_b;
  logic                    r_valid;
  logic signed [W_OUT-1:0] r_prod;

  logic [W_ENT-1:0]        w_wdata;
  logic [W_ENT-1:0]        w_rdata;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_issue;

`ifdef BSEQ_ACCUM_EN
  logic                    r_last;
  logic signed [W_OUT-1:0] r_acc;
  logic signed [W_OUT-1:0] w_acc_sum;

  assign w_wdata   = {in_last, in_b, in_a};
  assign w_acc_sum = r_acc + f_sext(mul_product);
`else
  logic                    w_unused_last;

  assign w_unused_last = in_last;
  assign w_wdata       = {in_b, in_a};
`endif

  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;

  // A new multiply is issued (and the FIFO head popped) whenever the FSM
  // is about to leave a state with nothing left to present.
  always_comb begin
    w_issue = 1'b0;
    if (!w_empty) begin
      case (r_state)
        IDLE:    w_issue = 1'b1;
        HOLD:    w_issue = out_ready;
`ifdef BSEQ_ACCUM_EN
        BUSY:    w_issue = mul_ready & ~r_last;
`endif
        default: w_issue = 1'b0;
      endcase
    end
  end

  bseq_fifo #(
    .W     (W_ENT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_issue),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_prod  <= '0;
`ifdef BSEQ_ACCUM_EN
      r_last  <= 1'b0;
      r_acc   <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: ;
        ISSUE: r_state <= BUSY;
        // mul_ready is still low in the first BUSY cycle because the
        // multiplier cleared it on the start pulse it just sampled.
        BUSY: begin
          if (mul_ready) begin
`ifdef BSEQ_ACCUM_EN
            r_acc <= w_acc_sum;
            if (r_last) begin
              r_prod  <= w_acc_sum;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end else begin
              r_state <= IDLE;
            end
`else
            r_prod  <= f_sext(mul_product);
            r_valid <= 1'b1;
            r_state <= HOLD;
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
`ifdef BSEQ_ACCUM_EN
            r_acc   <= '0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase

      // Issue overrides the fall-back to IDLE chosen above.
      if (w_issue) begin
        r_state <= ISSUE;
        r_start <= 1'b1;
        r_a     <= w_rdata[NB-1:0];
        r_b     <= w_rdata[2*NB-1:NB];
`ifdef BSEQ_ACCUM_EN
        r_last  <= w_rdata[2*NB];
`endif
      end
    end
  end

  assign mul_start   = r_start;
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign out_valid   = r_valid;
  assign out_product = r_prod;
  assign busy        = (r_state != IDLE) | ~w_empty;

endmodule
